wavelet_pe_multisink: RTL and testbench
=======================================

WAVELET_PE_MULTISINK -- requirements
Module: wavelet_pe_multisink

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, sample width.
REQ-002 SHALL have parameter CHANNELS, default 2, number of filter-band inputs (>=1).
REQ-003 SHALL have parameter OBUFF_CELL_COUNT, default 2048, output buffer depth.
REQ-004 SHALL have parameter SKID_DEPTH, default 2, per-channel FIFO depth (power of 2, >=2).
REQ-005 SHALL have derived parameter OBUFF_ADDR_WIDTH, default $clog2(OBUFF_CELL_COUNT), written as A below.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: ch_valid  in  CHANNELS  per-channel sample strobe; ch_data  in  CHANNELS*INPUT_WIDTH  samples, channel i at bits [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-008 SHALL have ports: ch_len  in  CHANNELS*A  outputs per pass per channel; ch_base_init  in  CHANNELS*A  initial base address per channel.
REQ-009 SHALL have ports: base_load  in  1  load bases from ch_base_init and clear offsets; base_advance  in  1  base += len and clear offsets; offset_rst  in  1  clear offsets only.
REQ-010 SHALL have ports: obuff_w_en  out  1; obuff_w_addr  out  A; obuff_w_data  out  INPUT_WIDTH.
REQ-011 SHALL have ports: ch_offset  out  CHANNELS*A  current offsets; ch_done  out  CHANNELS  pass-complete pulse; ch_overflow  out  CHANNELS  sticky drop flag; busy  out  1  any FIFO non-empty.

Function
REQ-012 SHALL push ch_data[i] into FIFO i on any cycle ch_valid[i]=1, FIFO not full, or full with a pop of FIFO i in the same cycle.
REQ-013 SHALL drop the sample and set ch_overflow[i] when ch_valid[i]=1, FIFO i full, and no pop of FIFO i in that cycle.
REQ-014 SHALL, each cycle, select at most one non-empty FIFO, pop it, and present its head registered: obuff_w_en=1 with data/address in the following cycle.
REQ-015 SHALL give minimum latency of one cycle: sample valid at edge N appears on obuff_w_* during cycle after edge N+1 when uncontended.
REQ-016 SHALL drive obuff_w_addr = (base[i] + offset[i]) mod 2^A for the popped channel i, sampled before that pop's offset update.
REQ-017 SHALL drive obuff_w_addr and obuff_w_data to 0 while obuff_w_en=0; never high-impedance.
REQ-018 SHALL increment offset[i] on each pop of channel i; when offset[i] = ch_len[i]-1 it SHALL wrap to 0 and ch_done[i] SHALL pulse high for one cycle aligned with that write's obuff_w_en.
REQ-019 SHALL treat ch_len[i]=0 as 2^A (offset wraps modulo 2^A).
REQ-020 SHALL apply base_load: base[i] <= ch_base_init[i], offset[i] <= 0, ch_overflow cleared; base_load SHALL take priority over base_advance and offset_rst.
REQ-021 SHALL apply base_advance: base[i] <= (base[i] + ch_len[i]) mod 2^A, offset[i] <= 0; offset_rst SHALL clear offsets only.
REQ-022 SHALL, on a control pulse coinciding with a pop, use pre-update base/offset for that write; the control update wins for the next state.
REQ-023 SHALL not flush FIFO contents on base_load, base_advance or offset_rst.
REQ-024 SHALL drive busy = OR of all FIFO non-empty flags (combinational).

Reset
REQ-025 SHALL, on rst=1 at a clk edge, clear all FIFOs, bases, offsets, ch_overflow, ch_done, obuff_w_en, obuff_w_addr, obuff_w_data to 0; rst overrides all other inputs.
REQ-026 SHALL discard in-flight samples when rst is asserted mid-operation; no write SHALL occur in the cycle after reset.

Configuration
REQ-027 SHALL support macro WAVELET_SINK_RR_ARB_EN: defined -> round-robin arbitration, pointer advancing to one past the last served channel; undefined -> fixed priority, lowest channel index wins.

Verification
REQ-028 Reset: rst high 2 cycles with ch_valid=all 1 -> all outputs 0, busy=0, no obuff_w_en after release until new input.
REQ-029 Single channel: CHANNELS=2, ch_base_init[0]=100, ch_len[0]=4, base_load, then 5 samples ch0 -> addresses 100,101,102,103,100; ch_done[0] on 4th write.
REQ-030 Contention: ch_valid=2'b11 for 3 cycles -> 6 writes, no overflow; fixed priority order 0,0,0,1,1,1 after... drain; RR order 0,1,0,1,0,1.
REQ-031 Overflow: SKID_DEPTH=2, ch1 valid 4 consecutive cycles while ch0 valid continuously (fixed priority) -> ch_overflow[1]=1, exactly 2 ch1 samples written after ch0 stops; base_load clears flag.
REQ-032 Wrap/advance: base=2040, ch_len=16, A=11 -> addresses 2040..2047,0..7; base_advance -> next write at address 8.

Source files
------------

// File: rtl/wavelet_pe_multisink.sv
// wavelet_pe_multisink: per-channel skid FIFOs arbitrated into one registered output-buffer write port (clk, rst, ch_valid/ch_data/ch_len/ch_base_init, base_load/base_advance/offset_rst -> obuff_w_en/addr/data, ch_offset, ch_done, ch_overflow, busy); WAVELET_SINK_RR_ARB_EN selects round-robin over fixed priority
module wavelet_pe_multisink #(
  parameter int INPUT_WIDTH = 32,
  parameter int CHANNELS = 2,
  parameter int OBUFF_CELL_COUNT = 2048,
  parameter int SKID_DEPTH = 2,
  parameter int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0]                  ch_valid,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]      ch_data,
  input  logic [CHANNELS*OBUFF_ADDR_WIDTH-1:0] ch_len,
  input  logic [CHANNELS*OBUFF_ADDR_WIDTH-1:0] ch_base_init,
  input  logic                                 base_load,
  input  logic                                 base_advance,
  input  logic                                 offset_rst,
  output logic                                 obuff_w_en,
  output logic [OBUFF_ADDR_WIDTH-1:0]          obuff_w_addr,
  output logic [INPUT_WIDTH-1:0]               obuff_w_data,
  output logic [CHANNELS*OBUFF_ADDR_WIDTH-1:0] ch_offset,
  output logic [CHANNELS-1:0]                  ch_done,
  output logic [CHANNELS-1:0]                  ch_overflow,
  output logic                                 busy
);
  localparam int A = OBUFF_ADDR_WIDTH;
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [INPUT_WIDTH-1:0] mem [CHANNELS][SKID_DEPTH];
  logic [PW-1:0] rd_ptr [CHANNELS];
  logic [PW-1:0] wr_ptr [CHANNELS];
  logic [PW:0] cnt [CHANNELS];
  logic [A-1:0] base [CHANNELS];
  logic [A-1:0] off [CHANNELS];
  logic [A-1:0] len [CHANNELS];
  logic [A-1:0] init [CHANNELS];
  logic [CHANNELS-1:0] nonempty, full, pop, push;
  logic sel_vld;
  logic [CW-1:0] sel;
`ifdef WAVELET_SINK_RR_ARB_EN
  logic [CW-1:0] rr_ptr;
`else
  localparam logic [CW-1:0] rr_ptr = '0;
`endif
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign len[g] = ch_len[g*A +: A];
    assign init[g] = ch_base_init[g*A +: A];
    assign ch_offset[g*A +: A] = off[g];
    assign nonempty[g] = cnt[g] != '0;
    assign full[g] = cnt[g] == (PW+1)'(SKID_DEPTH);
    assign pop[g] = sel_vld && sel == CW'(g);
    assign push[g] = ch_valid[g] && (!full[g] || pop[g]);
  end
  assign busy = |nonempty;
  // scan from the pointer downwards so the channel nearest the pointer is the last (winning) assignment
  always_comb begin : arb
    int idx;
    idx = 0;
    sel_vld = 1'b0;
    sel = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % CHANNELS;
      if (nonempty[idx]) begin
        sel_vld = 1'b1;
        sel = CW'(idx);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      obuff_w_en <= 1'b0;
      obuff_w_addr <= '0;
      obuff_w_data <= '0;
      ch_done <= '0;
      ch_overflow <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i] <= '0;
        base[i] <= '0;
        off[i] <= '0;
      end
`ifdef WAVELET_SINK_RR_ARB_EN
      rr_ptr <= '0;
`endif
    end else begin
      obuff_w_en <= sel_vld;
      obuff_w_addr <= sel_vld ? base[sel] + off[sel] : '0;
      obuff_w_data <= sel_vld ? mem[sel][rd_ptr[sel]] : '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= ch_data[i*INPUT_WIDTH +: INPUT_WIDTH];
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
        // len of 0 makes len-1 all ones, so the offset wraps at 2^A
        ch_done[i] <= pop[i] && off[i] == len[i] - A'(1);
        if (base_load) begin
          base[i] <= init[i];
          off[i] <= '0;
        end else if (base_advance) begin
          base[i] <= base[i] + len[i];
          off[i] <= '0;
        end else if (offset_rst)
          off[i] <= '0;
        else if (pop[i])
          off[i] <= off[i] == len[i] - A'(1) ? '0 : off[i] + 1'b1;
        if (base_load)
          ch_overflow[i] <= 1'b0;
        else if (ch_valid[i] && full[i] && !pop[i])
          ch_overflow[i] <= 1'b1;
      end
`ifdef WAVELET_SINK_RR_ARB_EN
      if (sel_vld)
        rr_ptr <= sel == CW'(CHANNELS - 1) ? '0 : sel + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_wavelet_pe_multisink.sv
// tb_wavelet_pe_multisink: queue-based reference model with per-cycle compare plus literal write-sequence checks
module tb_wavelet_pe_multisink;
  localparam int W = 32, CH = 2, A = 11, SKID = 4, M = 1 << A;
  logic clk = 0, rst = 1;
  logic [CH-1:0] ch_valid = '0;
  logic [CH*W-1:0] ch_data = '0;
  logic [CH*A-1:0] ch_len = '0, ch_base_init = '0;
  logic base_load = 0, base_advance = 0, offset_rst = 0;
  logic obuff_w_en, busy;
  logic [A-1:0] obuff_w_addr;
  logic [W-1:0] obuff_w_data;
  logic [CH*A-1:0] ch_offset;
  logic [CH-1:0] ch_done, ch_overflow;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  wavelet_pe_multisink #(.INPUT_WIDTH(W), .CHANNELS(CH), .OBUFF_CELL_COUNT(M), .SKID_DEPTH(SKID)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_len(ch_len),
    .ch_base_init(ch_base_init), .base_load(base_load), .base_advance(base_advance),
    .offset_rst(offset_rst), .obuff_w_en(obuff_w_en), .obuff_w_addr(obuff_w_addr),
    .obuff_w_data(obuff_w_data), .ch_offset(ch_offset), .ch_done(ch_done),
    .ch_overflow(ch_overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask
  logic [W-1:0] q [CH][$];
  int base_m [CH], off_m [CH], rr_m = 0;
  logic [CH-1:0] ovf_m = '0, done_m = '0;
  logic en_m = 0;
  logic [A-1:0] addr_m = '0;
  logic [W-1:0] data_m = '0;
  function automatic int lenv(input int i);
    int l;
    l = int'(ch_len[i*A +: A]);
    return l == 0 ? M : l;
  endfunction
  always @(posedge clk) begin : model
    int sel;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        q[i].delete();
        base_m[i] = 0;
        off_m[i] = 0;
      end
      rr_m = 0; ovf_m = '0; done_m = '0; en_m = 0; addr_m = '0; data_m = '0;
    end else begin
      sel = -1;
      for (int k = CH - 1; k >= 0; k--)
        if (q[(rr_m + k) % CH].size() > 0) sel = (rr_m + k) % CH;
      en_m = sel >= 0; done_m = '0; addr_m = '0; data_m = '0;
      if (sel >= 0) begin
        data_m = q[sel].pop_front();
        addr_m = A'((base_m[sel] + off_m[sel]) % M);
        done_m[sel] = off_m[sel] == lenv(sel) - 1;
        off_m[sel] = (off_m[sel] + 1) % lenv(sel);
`ifdef WAVELET_SINK_RR_ARB_EN
        rr_m = (sel + 1) % CH;
`endif
      end
      for (int i = 0; i < CH; i++)
        if (ch_valid[i]) begin
          if (q[i].size() < SKID) q[i].push_back(ch_data[i*W +: W]);
          else ovf_m[i] = 1;
        end
      for (int i = 0; i < CH; i++)
        if (base_load) begin
          base_m[i] = int'(ch_base_init[i*A +: A]); off_m[i] = 0; ovf_m[i] = 0;
        end else if (base_advance) begin
          base_m[i] = (base_m[i] + lenv(i)) % M; off_m[i] = 0;
        end else if (offset_rst) off_m[i] = 0;
    end
  end
  logic [A-1:0] la [$];
  logic [W-1:0] ld [$];
  logic [CH-1:0] ldn [$];
  always @(negedge clk) begin : compare
    logic [CH*A-1:0] eo;
    bit eb;
    if (chk_en) begin
      eb = 0;
      for (int i = 0; i < CH; i++) begin
        eo[i*A +: A] = A'(off_m[i]);
        if (q[i].size() > 0) eb = 1;
      end
      chk("w_en", obuff_w_en, en_m);
      chk("w_addr", obuff_w_addr, addr_m);
      chk("w_data", obuff_w_data, data_m);
      chk("done", ch_done, done_m);
      chk("overflow", ch_overflow, ovf_m);
      chk("offset", ch_offset, eo);
      chk("busy", busy, eb);
      if (obuff_w_en) begin
        la.push_back(obuff_w_addr); ld.push_back(obuff_w_data); ldn.push_back(ch_done);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr_log();
    la.delete(); ld.delete(); ldn.delete();
  endtask
  task automatic pulse_load();
    base_load = 1; step(1); base_load = 0;
  endtask
  logic [W-1:0] ord [6];
  int n1;
  initial begin
`ifdef WAVELET_SINK_RR_ARB_EN
    ord = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22};
`else
    ord = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22};
`endif
    ch_valid = '1; ch_data = {32'hdead, 32'hbeef};
    @(negedge clk); chk_en = 1; step(1);
    rst = 0; ch_valid = '0; step(3);
    chk("rst_en", obuff_w_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ch_overflow, 0);
    ch_len = {A'(8), A'(4)}; ch_base_init = {A'(200), A'(100)};
    pulse_load(); clr_log();
    for (int k = 0; k < 5; k++) begin
      ch_valid = 2'b01; ch_data[0 +: W] = W'(k + 1); step(1);
    end
    ch_valid = '0; step(3);
    chk("single_cnt", la.size(), 5);
    chk("single_a0", la[0], 100); chk("single_a1", la[1], 101); chk("single_a2", la[2], 102);
    chk("single_a3", la[3], 103); chk("single_a4", la[4], 100);
    chk("single_done3", ldn[3], 2'b01); chk("single_done2", ldn[2], 2'b00);
    rst = 1; step(1); rst = 0; pulse_load(); clr_log();
    for (int k = 0; k < 3; k++) begin
      ch_valid = 2'b11; ch_data = {W'(32'h20 + k), W'(32'h10 + k)}; step(1);
    end
    ch_valid = '0; step(6);
    chk("cont_cnt", la.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("cont_order%0d", k), ld[k], ord[k]);
    chk("cont_ovf", ch_overflow, 0);
    clr_log();
    for (int k = 0; k < 8; k++) begin
      ch_valid = {k < 6, 1'b1}; ch_data = {W'(32'h50 + k), W'(32'h40 + k)}; step(1);
    end
    ch_valid = '0; step(14);
`ifndef WAVELET_SINK_RR_ARB_EN
    n1 = 0;
    foreach (ld[k]) if (ld[k][7:4] == 4'h5) n1++;
    chk("ovf_flag", ch_overflow, 2'b10);
    chk("ovf_ch1_writes", n1, 4);
    chk("ovf_total", la.size(), 12);
`endif
    pulse_load();
    chk("ovf_cleared", ch_overflow, 0);
    ch_len[0 +: A] = A'(16); ch_base_init[0 +: A] = A'(2040);
    pulse_load(); clr_log();
    for (int k = 0; k < 16; k++) begin
      ch_valid = 2'b01; ch_data[0 +: W] = W'(k); step(1);
    end
    ch_valid = '0; step(3);
    chk("wrap_cnt", la.size(), 16);
    chk("wrap_first", la[0], 2040); chk("wrap_last_hi", la[7], 2047);
    chk("wrap_zero", la[8], 0); chk("wrap_end", la[15], 7);
    chk("wrap_done", ldn[15], 2'b01);
    base_advance = 1; step(1); base_advance = 0;
    ch_valid = 2'b01; ch_data[0 +: W] = 32'ha0; step(1);
    ch_data[0 +: W] = 32'ha1; step(1);
    ch_data[0 +: W] = 32'ha2; offset_rst = 1; step(1);
    offset_rst = 0; ch_valid = '0; step(3);
    chk("adv_addr", la[16], 8); chk("adv_addr2", la[17], 9); chk("orst_addr", la[18], 8);
    ch_valid = 2'b11; step(2);
    rst = 1; step(1);
    rst = 0; ch_valid = '0; step(1);
    chk("midrst_en", obuff_w_en, 0);
    chk("midrst_busy", busy, 0);
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
